// File: rtl/seq_detect_param_if.sv
// ----------------------------------------------------------------------------
// seq_detect_param_if
//   Bundles the serial stream, the run-time configuration and the detector
//   status outputs of seq_detect_param. clk and rst stay plain module ports.
//
//   master : stream/config source (drives data_in .. overlap_en)
//   slave  : the detector (drives out, armed, cfg_err, match_cnt)
//
//   data_in     serial data bit
//   in_valid    qualifies data_in
//   cfg_load    latch pattern/pat_len/overlap_en and restart the search
//   pattern     pattern bits, pattern[pat_len-1] is first on the wire
//   pat_len     active pattern length, legal 1..PAT_W
//   overlap_en  1 = overlapping matches, 0 = non-overlapping
//   out         one-cycle match pulse
//   armed       detector is searching
//   cfg_err     sticky illegal-length flag
//   match_cnt   saturating match count (zero unless MATCH_CNT_EN)
// ----------------------------------------------------------------------------
interface seq_detect_param_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) ();
    logic             data_in;
    logic             in_valid;
    logic             cfg_load;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] pat_len;
    logic             overlap_en;
    logic             out;
    logic             armed;
    logic             cfg_err;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output data_in, in_valid, cfg_load, pattern, pat_len, overlap_en,
        input  out, armed, cfg_err, match_cnt
    );

    modport slave (
        input  data_in, in_valid, cfg_load, pattern, pat_len, overlap_en,
        output out, armed, cfg_err, match_cnt
    );
endinterface

// File: rtl/seq_detect_param.sv
// ----------------------------------------------------------------------------
// seq_detect_param
//   Runtime-programmable serial bit-pattern detector. A pattern of 1..PAT_W
//   bits is loaded with cfg_load; every in_valid bit is shifted into a
//   history register and a registered one-cycle pulse on bus.out marks each
//   occurrence. Overlapping or non-overlapping detection is selectable.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous reset, active-low
//     bus   seq_detect_param_if.slave (stream, config, status)
//
//   Build option
//     MATCH_CNT_EN  when defined, bus.match_cnt is a saturating count of
//                   matches; otherwise it is tied to zero with no flops.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | unconfigured or last load illegal; data ignored
//   RUN   | configured; searching the qualified stream
// ----------------------------------------------------------------------------
module seq_detect_param #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    seq_detect_param_if.slave   bus
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t           state;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] fill_q;
    logic             ovl_q;
    logic             out_q;
    logic             armed_q;
    logic             err_q;

    logic             len_legal;
    logic [PAT_W-1:0] hist_next;
    logic [LEN_W-1:0] fill_next;
    logic             pat_eq;
    logic             hit;

    // Matching works on the post-shift history so the pulse follows the
    // edge that samples the final pattern bit.
    always_comb begin
        len_legal = (bus.pat_len != '0) && (int'(bus.pat_len) <= PAT_W);
        hist_next = {hist_q[PAT_W-2:0], bus.data_in};
        fill_next = (int'(fill_q) >= PAT_W) ? fill_q : fill_q + 1'b1;
        pat_eq    = 1'b1;
        for (int i = 0; i < PAT_W; i++) begin
            if ((i < int'(len_q)) && (hist_next[i] != pat_q[i])) begin
                pat_eq = 1'b0;
            end
        end
        // cfg_load takes priority over a coincident data bit.
        hit = (state == RUN) && bus.in_valid && !bus.cfg_load &&
              (fill_next >= len_q) && pat_eq;
    end

`ifdef MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hist_q  <= '0;
            pat_q   <= '0;
            len_q   <= '0;
            fill_q  <= '0;
            ovl_q   <= 1'b0;
            out_q   <= 1'b0;
            armed_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef MATCH_CNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            out_q <= hit;
            if (bus.cfg_load) begin
                hist_q <= '0;
                fill_q <= '0;
                if (len_legal) begin
                    pat_q   <= bus.pattern;
                    len_q   <= bus.pat_len;
                    ovl_q   <= bus.overlap_en;
                    err_q   <= 1'b0;
                    state   <= RUN;
                    armed_q <= 1'b1;
`ifdef MATCH_CNT_EN
                    cnt_q   <= '0;
`endif
                end else begin
                    err_q   <= 1'b1;
                    state   <= IDLE;
                    armed_q <= 1'b0;
                end
            end else if ((state == RUN) && bus.in_valid) begin
                hist_q <= hist_next;
                // Non-overlapping: a hit consumes its bits, so the next
                // match needs a full pattern of fresh bits.
                fill_q <= (hit && !ovl_q) ? '0 : fill_next;
`ifdef MATCH_CNT_EN
                if (hit && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
            end
        end
    end

    assign bus.out     = out_q;
    assign bus.armed   = armed_q;
    assign bus.cfg_err = err_q;
`ifdef MATCH_CNT_EN
    assign bus.match_cnt = cnt_q;
`else
    assign bus.match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
module tb_seq_detect_param;

    localparam int PAT_W = 8;
    localparam int LEN_W = 4;
    localparam int CNT_W = 2;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    seq_detect_param_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

    seq_detect_param #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int c);
`ifdef MATCH_CNT_EN
        return 32'(c);
`else
        return (c == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    // Load a configuration; called just after a rising edge.
    task automatic cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic ov);
        bus.cfg_load   = 1'b1;
        bus.in_valid   = 1'b0;
        bus.pattern    = p;
        bus.pat_len    = l;
        bus.overlap_en = ov;
        @(posedge clk); #1;
        bus.cfg_load   = 1'b0;
        bus.pattern    = '0;
        bus.pat_len    = '0;
    endtask

    // Drive a stream ('0'/'1' = valid bit, '-' = in_valid low) and compare
    // out after every cycle against the expected pulse string.
    task automatic stream(input string tag, input string bits, input string exp);
        for (int i = 0; i < bits.len(); i++) begin
            bus.in_valid = (bits[i] != "-");
            bus.data_in  = (bits[i] == "1") || (bits[i] == "-");
            @(posedge clk); #1;
            chk($sformatf("%s[%0d]", tag, i), 32'(bus.out), 32'(exp[i] == "1"));
        end
        bus.in_valid = 1'b0;
        bus.data_in  = 1'b0;
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b0;
        bus.data_in    = 1'b0;
        bus.in_valid   = 1'b0;
        bus.cfg_load   = 1'b0;
        bus.pattern    = '0;
        bus.pat_len    = '0;
        bus.overlap_en = 1'b0;
        #1;
        chk("por_out",   32'(bus.out),     32'd0);
        chk("por_armed", 32'(bus.armed),   32'd0);
        chk("por_err",   32'(bus.cfg_err), 32'd0);
        chk("por_cnt",   32'(bus.match_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // IDLE ignores data before any configuration
        stream("idle", "1111", "0000");

        // 1011 overlapping: hits after bits 6 and 11
        cfg(8'b0000_1011, 4'd4, 1'b1);
        chk("t2_armed", 32'(bus.armed), 32'd1);
        stream("t2", "10101101011", "00000100001");
        chk("t2_cnt", 32'(bus.match_cnt), exp_cnt(2));

        // 101 overlapping vs non-overlapping
        cfg(8'b0000_0101, 4'd3, 1'b1);
        stream("t3_ov", "10101", "00101");
        cfg(8'b0000_0101, 4'd3, 1'b0);
        stream("t3_nov", "10101", "00100");
        chk("t3_cnt", 32'(bus.match_cnt), exp_cnt(1));

        // in_valid gaps inside the pattern
        cfg(8'b0000_1011, 4'd4, 1'b1);
        stream("t4", "1011-01--1", "0001000001");

        // illegal lengths from RUN drop back to IDLE, stream ignored
        cfg(8'hFF, 4'd0, 1'b1);
        chk("t5_err0",   32'(bus.cfg_err), 32'd1);
        chk("t5_armed0", 32'(bus.armed),   32'd0);
        cfg(8'hFF, 4'd9, 1'b1);
        chk("t5_err9",   32'(bus.cfg_err), 32'd1);
        chk("t5_armed9", 32'(bus.armed),   32'd0);
        stream("t5_ign", "1111", "0000");
        cfg(8'h01, 4'd1, 1'b1);
        chk("t5_err_clr", 32'(bus.cfg_err), 32'd0);
        chk("t5_armed",   32'(bus.armed),   32'd1);

        // cfg_load coincident with a valid bit: bit dropped, no hit
        bus.cfg_load   = 1'b1;
        bus.in_valid   = 1'b1;
        bus.data_in    = 1'b1;
        bus.pattern    = 8'h01;
        bus.pat_len    = 4'd1;
        bus.overlap_en = 1'b1;
        @(posedge clk); #1;
        bus.cfg_load   = 1'b0;
        bus.in_valid   = 1'b0;
        chk("t6_coinc_out", 32'(bus.out), 32'd0);
        chk("t6_coinc_cnt", 32'(bus.match_cnt), exp_cnt(0));

        // len-1 pattern, back-to-back hits, counter saturates at 3
        stream("t6a", "11", "11");
        chk("t6_cnt2", 32'(bus.match_cnt), exp_cnt(2));
        stream("t6b", "1111", "1111");
        chk("t6_cnt_sat", 32'(bus.match_cnt), exp_cnt(3));

        // async reset mid-stream while out is high
        bus.in_valid = 1'b1;
        bus.data_in  = 1'b1;
        rst = 1'b0;
        #1;
        chk("rst_out",   32'(bus.out),       32'd0);
        chk("rst_armed", 32'(bus.armed),     32'd0);
        chk("rst_err",   32'(bus.cfg_err),   32'd0);
        chk("rst_cnt",   32'(bus.match_cnt), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        stream("post_rst", "111", "000");
        chk("post_rst_armed", 32'(bus.armed), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
